maze_path_stack: RTL and testbench

Storage and replay stage directly downstream of the maze stack controller. Holds the rat's move history as a LIFO of 2-bit directions: pushed while exploring forward, popped while backtracking. Once the solver has reached the exit, it replays the surviving path bottom-to-top, one move per cycle, to the move/display logic, then raises `finish` back to the controller.

---
 rtl/maze_path_stack_if.sv | 28 ++
 rtl/maze_path_stack.sv | 154 +++++++++++++++
 tb/tb_maze_path_stack.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/maze_path_stack_if.sv
// Handshake bundle between the maze stack controller (master) and the
// path stack (slave): push/pop/replay requests in, directions and status out.
interface maze_path_stack_if #(
  parameter int AW = 8
);
  logic          push;
  logic          pop;
  logic [1:0]    din;
  logic          start_move;
  logic [1:0]    dout;
  logic          dout_valid;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;
  logic          finish;

  modport master (
    output push, pop, din, start_move,
    input  dout, dout_valid, count, empty, full, overflow, underflow, finish
  );

  modport slave (
    input  push, pop, din, start_move,
    output dout, dout_valid, count, empty, full, overflow, underflow, finish
  );
endinterface

// File: rtl/maze_path_stack.sv
// LIFO of 2-bit move directions. Push/pop while exploring, then replay the
// stored path bottom-to-top one move per cycle and signal finish.
module maze_path_stack #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  maze_path_stack_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REPLAY, DONE} state_t;

  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE    = 1;
  localparam logic [AW-1:0] PTR_ONE    = 1;

  logic [1:0]    mem [DEPTH];

  state_t        state_reg, state_next;
  logic [AW-1:0] sp_reg, sp_next;
  logic [AW-1:0] rp_reg, rp_next;
  logic [AW:0]   count_reg, count_next;
  logic [1:0]    dout_reg, dout_next;
  logic          dout_valid_reg, dout_valid_next;
  logic          overflow_reg, overflow_next;
  logic          underflow_reg, underflow_next;
  logic          finish_reg, finish_next;
  logic          arm_reg, arm_next;   // start_move seen low while in DONE
  logic          mem_we;
  logic          access;
  logic          is_full, is_empty;
  logic [AW-1:0] sp_dec;

  assign is_full  = (count_reg == FULL_COUNT);
  assign is_empty = (count_reg == '0);
  assign sp_dec   = sp_reg - PTR_ONE;

  // Next-state and next-output decode for stack access and replay sequencing
  always_comb begin
    state_next      = state_reg;
    sp_next         = sp_reg;
    rp_next         = rp_reg;
    count_next      = count_reg;
    dout_next       = dout_reg;
    dout_valid_next = 1'b0;
    overflow_next   = overflow_reg;
    underflow_next  = underflow_reg;
    finish_next     = 1'b0;
    arm_next        = arm_reg;
    mem_we          = 1'b0;
    access          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.push || bus.pop) begin
          access = 1'b1;
        end else if (bus.start_move) begin
          rp_next    = '0;
          arm_next   = 1'b0;
          state_next = is_empty ? DONE : REPLAY;
        end
      end
      REPLAY: begin
        dout_next       = mem[rp_reg];
        dout_valid_next = 1'b1;
        rp_next         = rp_reg + PTR_ONE;
        if (rp_reg == sp_dec) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.push || bus.pop) begin
          // Leave DONE and perform the access in this same cycle
          access     = 1'b1;
          state_next = IDLE;
        end else if (bus.start_move && arm_reg) begin
          rp_next     = '0;
          arm_next    = 1'b0;
          state_next  = is_empty ? DONE : REPLAY;
          finish_next = is_empty;
        end else begin
          if (!bus.start_move) begin
            arm_next = 1'b1;
          end
          finish_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Push has priority; a simultaneous pop is dropped without underflow
    if (access) begin
      if (bus.push) begin
        if (!is_full) begin
          mem_we     = 1'b1;
          sp_next    = sp_reg + PTR_ONE;
          count_next = count_reg + CNT_ONE;
        end else begin
          overflow_next = 1'b1;
        end
      end else if (!is_empty) begin
        sp_next         = sp_dec;
        count_next      = count_reg - CNT_ONE;
        dout_next       = mem[sp_dec];
        dout_valid_next = 1'b1;
      end else begin
        underflow_next = 1'b1;
      end
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      sp_reg         <= '0;
      rp_reg         <= '0;
      count_reg      <= '0;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
      overflow_reg   <= 1'b0;
      underflow_reg  <= 1'b0;
      finish_reg     <= 1'b0;
      arm_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sp_reg         <= sp_next;
      rp_reg         <= rp_next;
      count_reg      <= count_next;
      dout_reg       <= dout_next;
      dout_valid_reg <= dout_valid_next;
      overflow_reg   <= overflow_next;
      underflow_reg  <= underflow_next;
      finish_reg     <= finish_next;
      arm_reg        <= arm_next;
    end
  end

  // Direction storage; contents become unreachable once sp is reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[sp_reg] <= bus.din;
    end
  end

  assign bus.dout       = dout_reg;
  assign bus.dout_valid = dout_valid_reg;
  assign bus.count      = count_reg;
  assign bus.empty      = is_empty;
  assign bus.full       = is_full;
  assign bus.overflow   = overflow_reg;
  assign bus.underflow  = underflow_reg;
  assign bus.finish     = finish_reg;
endmodule

// File: tb/tb_maze_path_stack.sv
// Directed plus random stimulus against a queue-based model of the path stack.
module tb_maze_path_stack;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  maze_path_stack_if #(.AW(AW)) bus ();

  maze_path_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the stack as a queue, a queue of moves still to replay
  logic [1:0] stk[$];
  logic [1:0] rq[$];
  bit         done_m, armed_m;
  logic [1:0] e_dout;
  bit         e_valid, e_ovf, e_unf, e_fin;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".dout_valid"}, 32'(bus.dout_valid), 32'(e_valid));
    chk({ctx, ".dout"},       32'(bus.dout),       32'(e_dout));
    chk({ctx, ".count"},      32'(bus.count),      32'(stk.size()));
    chk({ctx, ".empty"},      32'(bus.empty),      32'(stk.size() == 0));
    chk({ctx, ".full"},       32'(bus.full),       32'(stk.size() == DEPTH));
    chk({ctx, ".overflow"},   32'(bus.overflow),   32'(e_ovf));
    chk({ctx, ".underflow"},  32'(bus.underflow),  32'(e_unf));
    chk({ctx, ".finish"},     32'(bus.finish),     32'(e_fin));
  endtask

  task automatic model_reset();
    stk.delete();
    rq.delete();
    done_m = 0; armed_m = 0;
    e_dout = 2'd0; e_valid = 0; e_ovf = 0; e_unf = 0; e_fin = 0;
  endtask

  task automatic model_access(input bit p, input logic [1:0] d);
    if (p) begin
      if (stk.size() < DEPTH) stk.push_back(d);
      else e_ovf = 1;
    end else begin
      if (stk.size() > 0) begin
        e_dout  = stk.pop_back();
        e_valid = 1;
      end else begin
        e_unf = 1;
      end
    end
  endtask

  task automatic model_step(input bit p, input bit q, input logic [1:0] d, input bit s);
    e_valid = 0;
    if (rq.size() > 0) begin
      e_dout  = rq.pop_front();
      e_valid = 1;
      e_fin   = 0;
      if (rq.size() == 0) done_m = 1;
    end else if (!done_m) begin
      e_fin = 0;
      if (p || q) model_access(p, d);
      else if (s) begin
        armed_m = 0;
        if (stk.size() == 0) done_m = 1;
        else rq = stk;
      end
    end else begin
      if (p || q) begin
        done_m = 0;
        e_fin  = 0;
        model_access(p, d);
      end else if (s && armed_m) begin
        armed_m = 0;
        if (stk.size() == 0) e_fin = 1;
        else begin
          rq     = stk;
          done_m = 0;
          e_fin  = 0;
        end
      end else begin
        if (!s) armed_m = 1;
        e_fin = 1;
      end
    end
  endtask

  // One clock: apply inputs, advance model at the edge, check 1 time unit later
  task automatic cycle(input bit p, input bit q, input logic [1:0] d, input bit s, input string ctx);
    bus.push = p; bus.pop = q; bus.din = d; bus.start_move = s;
    @(posedge clk);
    model_step(p, q, d, s);
    #1;
    check_all(ctx);
    $display("cycle %s push=%0b pop=%0b din=%0d start=%0b -> dout=%0d v=%0b count=%0d fin=%0b",
             ctx, p, q, d, s, bus.dout, bus.dout_valid, bus.count, bus.finish);
  endtask

  // Asynchronous reset asserted mid-cycle, checked before the next edge
  task automatic do_reset(input string ctx);
    bus.push = 0; bus.pop = 0; bus.din = 0; bus.start_move = 0;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all({ctx, ".async"});
    @(posedge clk);
    #1;
    check_all({ctx, ".held"});
    rst = 1'b1;
    $display("reset %s released", ctx);
  endtask

  initial begin
    bus.push = 0; bus.pop = 0; bus.din = 0; bus.start_move = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("por");
    rst = 1'b1;

    // Reset behaviour
    cycle(1, 0, 2'd3, 0, "rst.push3");
    cycle(1, 0, 2'd1, 0, "rst.push1");
    do_reset("rst.mid");

    // LIFO order, then underflow
    cycle(1, 0, 2'd0, 0, "lifo.push0");
    cycle(1, 0, 2'd1, 0, "lifo.push1");
    cycle(1, 0, 2'd2, 0, "lifo.push2");
    cycle(1, 0, 2'd3, 0, "lifo.push3");
    for (int i = 0; i < 4; i++) cycle(0, 1, 2'd0, 0, "lifo.pop");
    cycle(0, 1, 2'd0, 0, "lifo.pop_empty");
    cycle(0, 0, 2'd0, 0, "lifo.idle");

    // Full and overflow, then simultaneous push and pop
    do_reset("full.rst");
    for (int i = 0; i < DEPTH; i++) cycle(1, 0, 2'(i), 0, "full.push");
    cycle(1, 0, 2'd2, 0, "full.overflow");
    cycle(0, 1, 2'd0, 0, "full.pop");
    cycle(1, 1, 2'd1, 0, "full.push_pop");

    // Replay, repeat, and exit from DONE
    do_reset("rep.rst");
    cycle(1, 0, 2'd1, 0, "rep.push");
    cycle(1, 0, 2'd1, 0, "rep.push");
    cycle(1, 0, 2'd2, 0, "rep.push");
    cycle(1, 0, 2'd3, 0, "rep.push");
    for (int i = 0; i < 7; i++) cycle(0, 0, 2'd0, 1, "rep.run");
    cycle(0, 0, 2'd0, 0, "rep.drop");
    for (int i = 0; i < 7; i++) cycle(0, 0, 2'd0, 1, "rep.again");
    cycle(1, 0, 2'd0, 0, "rep.exit_push");
    cycle(0, 0, 2'd0, 0, "rep.idle");

    // Empty replay
    do_reset("erep.rst");
    cycle(0, 0, 2'd0, 1, "erep.start");
    cycle(0, 0, 2'd0, 1, "erep.finish");
    cycle(0, 0, 2'd0, 0, "erep.hold");

    // Reset during the second replay cycle
    do_reset("arep.rst");
    cycle(1, 0, 2'd2, 0, "arep.push");
    cycle(1, 0, 2'd0, 0, "arep.push");
    cycle(1, 0, 2'd3, 0, "arep.push");
    cycle(0, 0, 2'd0, 1, "arep.start");
    cycle(0, 0, 2'd0, 1, "arep.first");
    do_reset("arep.abort");
    for (int i = 0; i < 5; i++) cycle(0, 0, 2'd0, 0, "arep.after");

    // Random traffic
    begin
      bit s_lvl = 0;
      for (int i = 0; i < 3000; i++) begin
        bit p, q;
        if ($urandom_range(0, 999) < 4) begin
          s_lvl = 0;
          do_reset("rnd.rst");
        end
        p = ($urandom_range(0, 99) < 35);
        q = ($urandom_range(0, 99) < 30);
        if ($urandom_range(0, 99) < 12) s_lvl = ~s_lvl;
        cycle(p, q, 2'($urandom_range(0, 3)), s_lvl, "rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
